// File: rtl/per_bus_pkg.sv
// Shared types and constants for the openMSP430 peripheral-bus initiator.
package per_bus_pkg;

    localparam int PER_AW_DEFAULT = 14;
    localparam int PER_DW_DEFAULT = 16;

    localparam logic [1:0] CMD_READ = 2'b00;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

endpackage

// File: rtl/per_bus_addr_gen.sv
// Burst beat counter with a wrapping word-address incrementer.
// Latency: loaded on command accept, steps on each non-final response handshake.
// Backpressure: none of its own; the master only steps it on a completed response.
module per_bus_addr_gen #(
    parameter int AW = 14
) (
    input  logic          mclk,
    input  logic          puc_rst,
    input  logic          load,
    input  logic          step,
    input  logic [AW-1:0] load_addr,
    input  logic [7:0]    load_len,
    output logic [AW-1:0] addr,
    output logic          last
);

    logic [7:0] beats_left;

    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            addr       <= '0;
            beats_left <= 8'd1;
        end else if (load) begin
            addr       <= load_addr;
            beats_left <= (load_len == 8'd0) ? 8'd1 : load_len;
        end else if (step) begin
            // Natural AW-bit overflow gives the 3FFF -> 0000 wrap.
            addr       <= addr + 1'b1;
            beats_left <= beats_left - 8'd1;
        end
    end

    assign last = (beats_left == 8'd1);

endmodule

// File: rtl/per_bus_master.sv
// Peripheral-bus initiator: one per_en cycle per beat; PER_BUS_MASTER_BURST_EN enables multi-beat bursts.
// Latency: accept -> per_en next cycle -> response the cycle after (3-cycle minimum period).
// Backpressure: cmd_ready only in IDLE; a stalled response holds the FSM in RESP with fields frozen.
module per_bus_master
    import per_bus_pkg::*;
#(
    parameter int PER_AW = PER_AW_DEFAULT,
    parameter int PER_DW = PER_DW_DEFAULT
) (
    input  logic              mclk,
    input  logic              puc_rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_we,
    input  logic [PER_AW-1:0] cmd_addr,
    input  logic [PER_DW-1:0] cmd_wdata,
    input  logic [7:0]        cmd_len,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [PER_DW-1:0] rsp_rdata,
    output logic              rsp_last,
    output logic              per_en,
    output logic [1:0]        per_we,
    output logic [PER_AW-1:0] per_addr,
    output logic [PER_DW-1:0] per_din,
    input  logic [PER_DW-1:0] per_dout,
    output logic              busy
);

    state_t            state_q, state_d;
    logic [1:0]        we_q;
    logic [PER_DW-1:0] wdata_q;
    logic [PER_AW-1:0] beat_addr;
    logic              beat_last;
    logic              accept;
    logic              rsp_done;

    assign accept   = (state_q == IDLE) && cmd_valid;
    assign rsp_done = (state_q == RESP) && rsp_ready;

    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cmd_valid) state_d = ACCESS;
            ACCESS:  state_d = RESP;
            RESP:    if (rsp_ready) state_d = beat_last ? IDLE : ACCESS;
            default: state_d = IDLE;
        endcase
    end

    // Bus fields are gated by per_en so nothing stale is left on the shared bus.
    always_comb begin
        cmd_ready = (state_q == IDLE) && !puc_rst;
        busy      = (state_q != IDLE);
        rsp_valid = (state_q == RESP);
        per_en    = (state_q == ACCESS);
        per_we    = per_en ? we_q      : 2'b00;
        per_addr  = per_en ? beat_addr : '0;
        per_din   = per_en ? wdata_q   : '0;
    end

    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            we_q    <= 2'b00;
            wdata_q <= '0;
        end else if (accept) begin
            we_q    <= cmd_we;
            wdata_q <= cmd_wdata;
        end
    end

    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            rsp_rdata <= '0;
            rsp_last  <= 1'b0;
        end else if (state_q == ACCESS) begin
            rsp_rdata <= (we_q == CMD_READ) ? per_dout : '0;
            rsp_last  <= beat_last;
        end
    end

`ifdef PER_BUS_MASTER_BURST_EN
    per_bus_addr_gen #(
        .AW(PER_AW)
    ) u_addr_gen (
        .mclk      (mclk),
        .puc_rst   (puc_rst),
        .load      (accept),
        .step      (rsp_done && !beat_last),
        .load_addr (cmd_addr),
        .load_len  (cmd_len),
        .addr      (beat_addr),
        .last      (beat_last)
    );
`else
    logic [PER_AW-1:0] addr_q;
    logic              unused_len;

    assign unused_len = ^{cmd_len, rsp_done};

    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            addr_q <= '0;
        end else if (accept) begin
            addr_q <= cmd_addr;
        end
    end

    assign beat_addr = addr_q;
    assign beat_last = 1'b1;
`endif

endmodule

// File: tb/tb_per_bus_master.sv
// Randomised bench for per_bus_master with a transaction-level model and a peripheral memory.
module tb_per_bus_master;

    localparam int AW = 14;
    localparam int DW = 16;

    logic          mclk = 1'b0;
    logic          puc_rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_we = 2'b00;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic [7:0]    cmd_len = 8'd0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_last;
    logic          per_en;
    logic [1:0]    per_we;
    logic [AW-1:0] per_addr;
    logic [DW-1:0] per_din;
    logic [DW-1:0] per_dout;
    logic          busy;

    per_bus_master #(.PER_AW(AW), .PER_DW(DW)) dut (
        .mclk(mclk), .puc_rst(puc_rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_len(cmd_len),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_last(rsp_last), .per_en(per_en), .per_we(per_we),
        .per_addr(per_addr), .per_din(per_din), .per_dout(per_dout), .busy(busy)
    );

    always #5 mclk = ~mclk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event did not occur as required", name);
    endtask

    // Peripheral side: a word memory that answers reads combinationally.
    logic [DW-1:0] periph_mem [0:16383];
    logic [DW-1:0] ref_mem    [0:16383];

    assign per_dout = (per_en && per_we == 2'b00) ? periph_mem[per_addr] : 16'h0000;

    always @(negedge mclk) begin
        if (per_en && per_we[0]) periph_mem[per_addr][7:0]  = per_din[7:0];
        if (per_en && per_we[1]) periph_mem[per_addr][15:8] = per_din[15:8];
    end

    // Response-ready driver.
    logic rdy_random = 1'b0;
    logic rdy_force  = 1'b1;
    always @(posedge mclk) begin
        #1;
        rsp_ready = rdy_random ? 1'($urandom_range(0, 1)) : rdy_force;
    end

    // Transaction model: expected bus beats and expected responses.
    typedef struct { logic [1:0] we; logic [AW-1:0] addr; logic [DW-1:0] wd; logic last; } acc_t;
    typedef struct { logic [DW-1:0] rd; logic last; } rsp_t;
    acc_t acc_q[$];
    rsp_t rsp_q[$];

    logic [AW-1:0] en_log[$];
    logic          last_log[$];
    logic [1:0]    last_en_we;
    logic [DW-1:0] last_en_din;
    logic [DW-1:0] last_rdata;
    logic exp_en = 1'b0, exp_rsp = 1'b0, exp_idle = 1'b0;

    always @(negedge mclk) begin
        acc_t a;
        rsp_t r;
        int   n;
        if (puc_rst) begin
            acc_q.delete();
            rsp_q.delete();
            exp_en = 1'b0; exp_rsp = 1'b0; exp_idle = 1'b0;
            chk("rst_cmd_ready", 32'(cmd_ready), 0);
            chk("rst_rsp", {rsp_valid, rsp_last, busy, per_en, 12'h0, rsp_rdata}, 0);
            chk("rst_bus", {per_we, per_addr, per_din}, 0);
        end else begin
            chk("ready_iff_idle", 32'(cmd_ready), 32'(!busy));
            if (exp_en)   chk("beat_timing", 32'(per_en), 1);
            if (exp_rsp)  chk("rsp_timing", 32'(rsp_valid), 1);
            if (exp_idle) chk("ready_after_last", 32'(cmd_ready), 1);
            exp_en = 1'b0; exp_rsp = 1'b0; exp_idle = 1'b0;
            if (!per_en) begin
                chk("bus_idle", {per_we, per_addr, per_din}, 0);
            end else begin
                chk("en_during_rsp", 32'(rsp_valid), 0);
                if (acc_q.size() == 0) begin
                    fail("unexpected_per_en");
                end else begin
                    a = acc_q.pop_front();
                    chk("per_we", 32'(per_we), 32'(a.we));
                    chk("per_addr", 32'(per_addr), 32'(a.addr));
                    chk("per_din", 32'(per_din), 32'(a.wd));
                    r.last = a.last;
                    if (a.we == 2'b00) begin
                        r.rd = ref_mem[a.addr];
                    end else begin
                        if (a.we[0]) ref_mem[a.addr][7:0]  = a.wd[7:0];
                        if (a.we[1]) ref_mem[a.addr][15:8] = a.wd[15:8];
                        r.rd = 16'h0000;
                    end
                    rsp_q.push_back(r);
                    exp_rsp = 1'b1;
                end
                en_log.push_back(per_addr);
                last_en_we  = per_we;
                last_en_din = per_din;
            end
            if (rsp_valid) begin
                if (rsp_q.size() == 0) begin
                    fail("unexpected_rsp");
                end else begin
                    chk("rsp_rdata", 32'(rsp_rdata), 32'(rsp_q[0].rd));
                    chk("rsp_last", 32'(rsp_last), 32'(rsp_q[0].last));
                    if (rsp_ready) begin
                        r = rsp_q.pop_front();
                        last_log.push_back(rsp_last);
                        last_rdata = rsp_rdata;
                        if (r.last) exp_idle = 1'b1;
                        else        exp_en   = 1'b1;
                    end
                end
            end
            if (cmd_valid && cmd_ready) begin
`ifdef PER_BUS_MASTER_BURST_EN
                n = (cmd_len == 8'd0) ? 1 : int'(cmd_len);
`else
                n = 1;
`endif
                for (int i = 0; i < n; i++) begin
                    a.we   = cmd_we;
                    a.addr = AW'((int'(cmd_addr) + i) % 16384);
                    a.wd   = cmd_wdata;
                    a.last = (i == n - 1);
                    acc_q.push_back(a);
                end
                exp_en = 1'b1;
            end
        end
    end

    // Called right after a rising edge (+1); returns at the same phase.
    task automatic issue(input logic [1:0] we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wd, input logic [7:0] len);
        int n;
        n = 0;
        cmd_we = we; cmd_addr = addr; cmd_wdata = wd; cmd_len = len;
        cmd_valid = 1'b1;
        @(negedge mclk);
        while (!cmd_ready && n < 200) begin
            @(negedge mclk);
            n++;
        end
        if (!cmd_ready) fail("issue_timeout");
        @(posedge mclk);
        #1;
        cmd_valid = 1'b0;
        cmd_we    = 2'($urandom);
        cmd_addr  = AW'($urandom);
        cmd_wdata = DW'($urandom);
        cmd_len   = 8'($urandom);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge mclk);
            n++;
        end while (!cmd_ready && n < 300);
        if (!cmd_ready) fail("idle_timeout");
        @(posedge mclk);
        #1;
    endtask

    task automatic clear_logs();
        en_log.delete();
        last_log.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 16384; i++) begin
            periph_mem[i] = DW'($urandom);
            ref_mem[i]    = periph_mem[i];
        end
        repeat (3) @(posedge mclk);
        #1;
        puc_rst = 1'b0;

        // Write the low byte of register 0x0010, then read it back.
        issue(2'b01, 14'h0010, 16'h00A5, 8'd0);
        wait_idle();
        clear_logs();
        issue(2'b00, 14'h0010, 16'hFFFF, 8'd0);
        wait_idle();
        chk("rd_beats", en_log.size(), 1);
        chk("rd_addr", 32'(en_log[0]), 32'h0010);
        chk("rd_we", 32'(last_en_we), 0);
        chk("rd_data_lo", 32'(last_rdata[7:0]), 32'hA5);
        chk("rd_last", 32'(last_log[0]), 1);

        // Byte write: response data must be zero.
        clear_logs();
        issue(2'b01, 14'h0020, 16'h1234, 8'd0);
        wait_idle();
        chk("wr_we", 32'(last_en_we), 32'h1);
        chk("wr_din", 32'(last_en_din), 32'h1234);
        chk("wr_rdata", 32'(last_rdata), 0);

        // Response stall: nothing else may happen on the bus.
        clear_logs();
        rdy_force = 1'b0;
        issue(2'b00, 14'h0010, 16'h0000, 8'd0);
        repeat (2) @(negedge mclk);
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", 32'(rsp_valid), 1);
            chk("stall_cmd_ready", 32'(cmd_ready), 0);
            chk("stall_rdata_lo", 32'(rsp_rdata[7:0]), 32'hA5);
            @(negedge mclk);
        end
        rdy_force = 1'b1;
        @(posedge mclk);
        #1;
        wait_idle();
        chk("stall_beats", en_log.size(), 1);

        // Reset while a response is pending.
        clear_logs();
        rdy_force = 1'b0;
        issue(2'b00, 14'h0020, 16'h0000, 8'd0);
        repeat (2) @(negedge mclk);
        @(posedge mclk);
        #3;
        puc_rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(rsp_valid), 0);
        chk("async_rst_busy", 32'(busy), 0);
        chk("async_rst_ready", 32'(cmd_ready), 0);
        @(posedge mclk);
        #1;
        puc_rst = 1'b0;
        rdy_force = 1'b1;
        chk("rst_dropped_rsp", last_log.size(), 0);
        @(posedge mclk);
        #1;
        clear_logs();
        issue(2'b00, 14'h0020, 16'h0000, 8'd0);
        wait_idle();
        chk("post_rst_data_lo", 32'(last_rdata[7:0]), 32'h34);
        chk("post_rst_last", 32'(last_log[0]), 1);

        // Burst across the top of the address space.
        clear_logs();
        issue(2'b00, 14'h3FFE, 16'h0000, 8'd3);
        wait_idle();
`ifdef PER_BUS_MASTER_BURST_EN
        chk("burst_beats", en_log.size(), 3);
        chk("burst_addr0", 32'(en_log[0]), 32'h3FFE);
        chk("burst_addr1", 32'(en_log[1]), 32'h3FFF);
        chk("burst_addr2", 32'(en_log[2]), 32'h0000);
        chk("burst_lasts", {29'h0, last_log[0], last_log[1], last_log[2]}, 32'h1);
`else
        chk("len_ignored_beats", en_log.size(), 1);
        chk("len_ignored_addr", 32'(en_log[0]), 32'h3FFE);
        chk("len_ignored_last", 32'(last_log[0]), 1);
`endif

        // Zero length is a single beat.
        clear_logs();
        issue(2'b11, 14'h0005, 16'hBEEF, 8'd0);
        wait_idle();
        chk("len0_beats", en_log.size(), 1);
        chk("len0_last", 32'(last_log[0]), 1);

        // Randomised traffic with random response backpressure.
        rdy_random = 1'b1;
        for (int k = 0; k < 80; k++) begin
            logic [AW-1:0] a;
            a = ($urandom_range(0, 3) == 0) ? AW'(14'h3FFC + $urandom_range(0, 3))
                                            : AW'($urandom_range(0, 7));
            issue(($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(1, 3)),
                  a, DW'($urandom), 8'($urandom_range(0, 4)));
            repeat ($urandom_range(0, 2)) begin
                @(posedge mclk);
                #1;
            end
        end
        rdy_random = 1'b0;
        rdy_force  = 1'b1;
        @(posedge mclk);
        #1;
        wait_idle();
        chk("drain_acc", acc_q.size(), 0);
        chk("drain_rsp", rsp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
